// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, BranchUnit training and statistics signals of the branch predictor.
// The master side drives PCs and resolved outcomes; the slave is the predictor.
interface branch_predictor_if;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_token;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output pred_pc,
    output upd_valid,
    output upd_pc,
    output upd_is_jump,
    output upd_token,
    output upd_target,
    output upd_pred_taken,
    output upd_pred_target,
    input  pred_taken,
    input  pred_target,
    input  mispredict,
    input  stat_branches,
    input  stat_mispredicts
  );

  modport slave (
    input  pred_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_is_jump,
    input  upd_token,
    input  upd_target,
    input  upd_pred_taken,
    input  upd_pred_target,
    output pred_taken,
    output pred_target,
    output mispredict,
    output stat_branches,
    output stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational lookup,
// single-port training from BranchUnit and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES      = 16,
  parameter logic [1:0]  CTR_ALLOC_BR = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IdxW;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [TagW-1:0] tag_t;

  logic [ENTRIES-1:0] valid_q;
  tag_t               tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Lookup
  idx_t pred_idx;
  tag_t pred_tag;
  logic pred_hit;

  assign pred_idx       = bp.pred_pc[IdxW+1:2];
  assign pred_tag       = bp.pred_pc[31:IdxW+2];
  assign pred_hit       = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign bp.pred_taken  = pred_hit & ctr_q[pred_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[pred_idx] : bp.pred_pc + 32'd4;

  // Training
  idx_t       upd_idx;
  tag_t       upd_tag;
  logic       upd_hit;
  logic [1:0] upd_ctr;
  logic       wr_en;
  logic       wr_tgt_en;
  logic [1:0] wr_ctr;
  logic       unused_upd_lsb;

  assign upd_idx        = bp.upd_pc[IdxW+1:2];
  assign upd_tag        = bp.upd_pc[31:IdxW+2];
  assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr        = ctr_q[upd_idx];
  assign unused_upd_lsb = ^bp.upd_pc[1:0];

  always_comb begin
    wr_en     = 1'b0;
    wr_tgt_en = 1'b0;
    wr_ctr    = upd_ctr;
    if (bp.upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bp.upd_is_jump) begin
          wr_ctr    = 2'd3;
          wr_tgt_en = 1'b1;
        end else if (bp.upd_token) begin
          wr_ctr    = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
          wr_tgt_en = 1'b1;
        end else begin
          wr_ctr = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
        end
      end else if (bp.upd_token) begin
        // Allocation evicts whatever alias occupies the slot.
        wr_en     = 1'b1;
        wr_tgt_en = 1'b1;
        wr_ctr    = bp.upd_is_jump ? 2'd3 : CTR_ALLOC_BR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload fields need no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      ctr_q[upd_idx] <= wr_ctr;
      if (wr_tgt_en) begin
        target_q[upd_idx] <= bp.upd_target;
      end
    end
  end

  // Misprediction and statistics
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  assign bp.mispredict = bp.upd_valid &
                         ((bp.upd_token != bp.upd_pred_taken) |
                          (bp.upd_token & (bp.upd_target != bp.upd_pred_target)));

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bp.upd_valid && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (bp.mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random training
// traffic, all compared against an array-based model of the prediction table.
module tb_branch_predictor;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp ();

  branch_predictor #(
    .ENTRIES      (ENTRIES),
    .CTR_ALLOC_BR (2'b10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model
  bit          m_valid [ENTRIES];
  logic [31:0] m_tagv  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tagv[m_idx(pc)] == m_tag(pc));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispred(input bit tok, input bit ptk,
                                   input logic [31:0] tgt, input logic [31:0] ptgt);
    return (tok != ptk) || (tok && (tgt != ptgt));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_br = '0;
    m_mp = '0;
  endtask

  task automatic m_train(input logic [31:0] pc, input bit jump, input bit tok,
                         input logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    if (m_hit(pc)) begin
      if (jump) begin
        m_ctr[i] = 3;
        m_tgt[i] = tgt;
      end else if (tok) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tok) begin
      m_valid[i] = 1'b1;
      m_tagv[i]  = m_tag(pc);
      m_tgt[i]   = tgt;
      m_ctr[i]   = jump ? 3 : 2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc);
    bp.pred_pc = pc;
    #1;
    check({tag, "_taken"}, 32'(bp.pred_taken), 32'(m_ptaken(pc)));
    check({tag, "_target"}, bp.pred_target, m_ptarget(pc));
  endtask

  task automatic check_const(input string tag, input logic [31:0] pc, input bit tk,
                             input logic [31:0] tgt);
    bp.pred_pc = pc;
    #1;
    check({tag, "_taken_c"}, 32'(bp.pred_taken), 32'(tk));
    check({tag, "_target_c"}, bp.pred_target, tgt);
  endtask

  // One training cycle with a simultaneous lookup of lpc; rst is honoured as set by caller.
  task automatic upd(input string tag, input logic [31:0] pc, input bit jump, input bit tok,
                     input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                     input logic [31:0] lpc);
    bit mp;
    bp.upd_valid       = 1'b1;
    bp.upd_pc          = pc;
    bp.upd_is_jump     = jump;
    bp.upd_token       = tok;
    bp.upd_target      = tgt;
    bp.upd_pred_taken  = ptk;
    bp.upd_pred_target = ptgt;
    bp.pred_pc         = lpc;
    #1;
    mp = m_mispred(tok, ptk, tgt, ptgt);
    check({tag, "_mp"}, 32'(bp.mispredict), 32'(mp));
    check({tag, "_rd_taken"}, 32'(bp.pred_taken), 32'(m_ptaken(lpc)));
    check({tag, "_rd_target"}, bp.pred_target, m_ptarget(lpc));
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      m_train(pc, jump, tok, tgt);
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (mp && (m_mp != 32'hFFFF_FFFF)) m_mp++;
    end
    @(negedge clk);
    bp.upd_valid = 1'b0;
    #1;
    check({tag, "_stat_br"}, bp.stat_branches, m_br);
    check({tag, "_stat_mp"}, bp.stat_mispredicts, m_mp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    bp.pred_pc         = '0;
    bp.upd_valid       = 1'b0;
    bp.upd_pc          = '0;
    bp.upd_is_jump     = 1'b0;
    bp.upd_token       = 1'b0;
    bp.upd_target      = '0;
    bp.upd_pred_taken  = 1'b0;
    bp.upd_pred_target = '0;
    rst                = 1'b1;
    @(negedge clk);
    do_reset();

    // Empty table after reset
    #1;
    check("rst_mp", 32'(bp.mispredict), 32'd0);
    check("rst_stat_br", bp.stat_branches, 32'd0);
    check("rst_stat_mp", bp.stat_mispredicts, 32'd0);
    for (int pc = 0; pc <= 'h3C; pc += 4) check_const("sweep", 32'(pc), 1'b0, 32'(pc + 4));

    // Taken branch training and counter walk
    upd("tr1", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    check_const("tr1_after", 32'h100, 1'b1, 32'h80);
    upd("tr_nt1", 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 32'h100);
    upd("tr_nt2", 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104, 32'h100);
    check_const("tr_nt2_after", 32'h100, 1'b0, 32'h104);
    upd("tr_t3", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    check_const("tr_t3_after", 32'h100, 1'b0, 32'h104);

    // JAL allocation and target mispredict
    upd("jal", 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204, 32'h200);
    check_const("jal_after", 32'h200, 1'b1, 32'h400);
    upd("jal_tgt", 32'h200, 1'b1, 1'b1, 32'h400, 1'b1, 32'h404, 32'h200);

    // Aliasing on the same index
    do_reset();
    upd("al_tr", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    upd("al_nt", 32'h140, 1'b0, 1'b0, 32'h99c, 1'b0, 32'h144, 32'h100);
    check_const("al_keep", 32'h100, 1'b1, 32'h80);
    upd("al_t", 32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144, 32'h100);
    check_const("al_evict", 32'h100, 1'b0, 32'h104);
    check_const("al_new", 32'h140, 1'b1, 32'h300);

    // Read-old on same-cycle update and lookup
    do_reset();
    upd("same", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    check_const("same_next", 32'h100, 1'b1, 32'h80);

    // Reset beats a simultaneous update
    do_reset();
    rst = 1'b1;
    upd("rstupd", 32'h180, 1'b0, 1'b1, 32'h90, 1'b0, 32'h184, 32'h180);
    rst = 1'b0;
    check_const("rstupd_tbl", 32'h180, 1'b0, 32'h184);
    check("rstupd_br_c", bp.stat_branches, 32'd0);
    check("rstupd_mp_c", bp.stat_mispredicts, 32'd0);

    // PC wrap-around
    check_const("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Random training traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, lpc, tgt, ptgt;
      bit jump, tok, ptk;
      pc   = pick_pc();
      lpc  = ($urandom_range(0, 1) == 0) ? pc : pick_pc();
      jump = ($urandom_range(0, 3) == 0);
      tok  = jump ? ($urandom_range(0, 7) != 0) : bit'($urandom_range(0, 1));
      tgt  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) begin
        ptk  = m_ptaken(pc);
        ptgt = m_ptarget(pc);
        if (tok && ($urandom_range(0, 1) == 0) && m_hit(pc)) tgt = m_tgt[m_idx(pc)];
      end else begin
        ptk  = bit'($urandom_range(0, 1));
        ptgt = $urandom & 32'hFFFF_FFFC;
      end
      rst = ($urandom_range(0, 59) == 0);
      upd("rnd", pc, jump, tok, tgt, ptk, ptgt, lpc);
      rst = 1'b0;
      if ((n % 8) == 0) check_pred("rnd_look", pick_pc());
    end

    // Statistic saturation: preload both counters one below the ceiling
    force dut.stat_br_q = 32'hFFFF_FFFE;
    force dut.stat_mp_q = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.stat_br_q;
    release dut.stat_mp_q;
    m_br = 32'hFFFF_FFFE;
    m_mp = 32'hFFFF_FFFE;
    #1;
    check("sat_pre_br", bp.stat_branches, 32'hFFFF_FFFE);
    check("sat_pre_mp", bp.stat_mispredicts, 32'hFFFF_FFFE);
    upd("sat1", 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h304, 32'h300);
    upd("sat2", 32'h300, 1'b0, 1'b0, 32'h500, 1'b1, 32'h500, 32'h300);
    check("sat2_br_c", bp.stat_branches, 32'hFFFF_FFFF);
    check("sat2_mp_c", bp.stat_mispredicts, 32'hFFFF_FFFF);
    upd("sat3", 32'h300, 1'b0, 1'b1, 32'h700, 1'b0, 32'h304, 32'h300);
    check("sat3_br_c", bp.stat_branches, 32'hFFFF_FFFF);
    check("sat3_mp_c", bp.stat_mispredicts, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
